// File: rtl/hdr_engine_sched.sv
// HDR-DDR command scheduler: pops one descriptor, runs the CCC or normal-transfer engine,
// grants it the shared datapath, then emits a Restart or Exit pattern and returns a response.
module hdr_engine_sched #(
  parameter int unsigned TIMEOUT_CYCLES = 4095,
  parameter int unsigned CNT_W          = 12,
  parameter logic [3:0]  EXIT_MODE      = 4'd10,
  parameter logic [3:0]  RESTART_MODE   = 4'd11
) (
  input  logic        i_sys_clk,
  input  logic        i_sys_rst,
  input  logic        i_sched_en,
  input  logic        i_regf_cmd_valid,
  input  logic        i_regf_CP,
  input  logic        i_regf_TOC,
  output logic        o_regf_cmd_pop,
  output logic        o_ccc_en,
  input  logic        i_ccc_done,
  input  logic [3:0]  i_ccc_err_status,
  input  logic [16:0] i_ccc_ctrl,
  output logic        o_nt_en,
  input  logic        i_nt_done,
  input  logic [3:0]  i_nt_err_status,
  input  logic [16:0] i_nt_ctrl,
  input  logic        i_tx_mode_done,
  output logic [16:0] o_ctrl,
  output logic        o_resp_valid,
  output logic [3:0]  o_resp_err_status,
  output logic        o_resp_is_ccc,
  output logic        o_sched_done
);

  typedef enum logic [2:0] {
    StIdle, StFetch, StCccRun, StNtRun, StResp, StRestart, StExit
  } state_e;

  // Watchdog fires on the cycle the counter would reach TIMEOUT_CYCLES.
  localparam logic [CNT_W-1:0] WdLast = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic             cp_q, cp_d;
  logic             toc_q, toc_d;
  logic [3:0]       err_q, err_d;
  logic             resp_is_ccc_q, resp_is_ccc_d;
  logic [CNT_W-1:0] wd_q, wd_d;
  logic             ccc_en_q, ccc_en_d;
  logic             nt_en_q, nt_en_d;
  logic             sched_done_q, sched_done_d;

  always_comb begin
    state_d       = state_q;
    cp_d          = cp_q;
    toc_d         = toc_q;
    err_d         = err_q;
    resp_is_ccc_d = resp_is_ccc_q;
    wd_d          = wd_q;
    ccc_en_d      = 1'b0;
    nt_en_d       = 1'b0;
    sched_done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_sched_en && i_regf_cmd_valid) begin
          state_d = StFetch;
          wd_d    = '0;
        end
      end
      StFetch: begin
        cp_d     = i_regf_CP;
        toc_d    = i_regf_TOC;
        ccc_en_d = i_regf_CP;
        nt_en_d  = ~i_regf_CP;
        state_d  = i_regf_CP ? StCccRun : StNtRun;
      end
      StCccRun: begin
        wd_d     = wd_q + 1'b1;
        ccc_en_d = 1'b1;
        if (i_ccc_done) begin
          err_d    = i_ccc_err_status;
          ccc_en_d = 1'b0;
          state_d  = StResp;
        end else if (wd_q == WdLast) begin
          err_d    = 4'hF;
          ccc_en_d = 1'b0;
          state_d  = StResp;
        end
        resp_is_ccc_d = (state_d == StResp) ? 1'b1 : resp_is_ccc_q;
      end
      StNtRun: begin
        wd_d    = wd_q + 1'b1;
        nt_en_d = 1'b1;
        if (i_nt_done) begin
          err_d   = i_nt_err_status;
          nt_en_d = 1'b0;
          state_d = StResp;
        end else if (wd_q == WdLast) begin
          err_d   = 4'hF;
          nt_en_d = 1'b0;
          state_d = StResp;
        end
        resp_is_ccc_d = (state_d == StResp) ? 1'b0 : resp_is_ccc_q;
      end
      StResp: begin
        state_d = (toc_q || (err_q != 4'h0)) ? StExit : StRestart;
      end
      StRestart: begin
        if (i_tx_mode_done) state_d = StIdle;
      end
      StExit: begin
        if (i_tx_mode_done) begin
          state_d      = StIdle;
          sched_done_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    // Abort: drop everything, and keep the response registers untouched.
    if (!i_sched_en && (state_q != StIdle)) begin
      state_d       = StIdle;
      ccc_en_d      = 1'b0;
      nt_en_d       = 1'b0;
      sched_done_d  = 1'b0;
      err_d         = err_q;
      resp_is_ccc_d = resp_is_ccc_q;
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state_q       <= StIdle;
      cp_q          <= 1'b0;
      toc_q         <= 1'b0;
      err_q         <= 4'h0;
      resp_is_ccc_q <= 1'b0;
      wd_q          <= '0;
      ccc_en_q      <= 1'b0;
      nt_en_q       <= 1'b0;
      sched_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cp_q          <= cp_d;
      toc_q         <= toc_d;
      err_q         <= err_d;
      resp_is_ccc_q <= resp_is_ccc_d;
      wd_q          <= wd_d;
      ccc_en_q      <= ccc_en_d;
      nt_en_q       <= nt_en_d;
      sched_done_q  <= sched_done_d;
    end
  end

  always_comb begin
    o_ctrl = '0;
    unique case (state_q)
      StCccRun: o_ctrl = i_ccc_ctrl;
      StNtRun:  o_ctrl = i_nt_ctrl;
      StRestart: begin
        o_ctrl[0]   = 1'b1;
        o_ctrl[4:1] = RESTART_MODE;
        o_ctrl[16]  = 1'b1;
      end
      StExit: begin
        o_ctrl[0]   = 1'b1;
        o_ctrl[4:1] = EXIT_MODE;
        o_ctrl[16]  = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end

  assign o_regf_cmd_pop    = (state_q == StFetch);
  assign o_resp_valid      = (state_q == StResp);
  assign o_ccc_en          = ccc_en_q;
  assign o_nt_en           = nt_en_q;
  assign o_resp_err_status = err_q;
  assign o_resp_is_ccc     = resp_is_ccc_q;
  assign o_sched_done      = sched_done_q;

  one_engine_en: assert property (@(posedge i_sys_clk) !(ccc_en_q && nt_en_q));

endmodule

// File: tb/tb_hdr_engine_sched.sv
// Directed bench for hdr_engine_sched: DUT a uses default parameters, DUT b a 16-cycle watchdog.
module tb_hdr_engine_sched;

  localparam logic [16:0] CtrlRestart = 17'h10017;
  localparam logic [16:0] CtrlExit    = 17'h10015;

  logic        clk = 1'b0;
  logic        rst;
  logic        sched_en_a, sched_en_b;
  logic        cmd_valid, cp, toc;
  logic        ccc_done, nt_done, tx_done;
  logic [3:0]  ccc_err, nt_err;
  logic [16:0] ccc_ctrl, nt_ctrl;

  logic        pop_a, ccc_en_a, nt_en_a, resp_valid_a, is_ccc_a, sdone_a;
  logic [3:0]  err_a;
  logic [16:0] ctrl_a;
  logic        pop_b, ccc_en_b, nt_en_b, resp_valid_b, is_ccc_b, sdone_b;
  logic [3:0]  err_b;
  logic [16:0] ctrl_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #10 clk = ~clk;

  hdr_engine_sched u_dut_a (
    .i_sys_clk(clk), .i_sys_rst(rst), .i_sched_en(sched_en_a),
    .i_regf_cmd_valid(cmd_valid), .i_regf_CP(cp), .i_regf_TOC(toc),
    .o_regf_cmd_pop(pop_a), .o_ccc_en(ccc_en_a), .i_ccc_done(ccc_done),
    .i_ccc_err_status(ccc_err), .i_ccc_ctrl(ccc_ctrl), .o_nt_en(nt_en_a),
    .i_nt_done(nt_done), .i_nt_err_status(nt_err), .i_nt_ctrl(nt_ctrl),
    .i_tx_mode_done(tx_done), .o_ctrl(ctrl_a), .o_resp_valid(resp_valid_a),
    .o_resp_err_status(err_a), .o_resp_is_ccc(is_ccc_a), .o_sched_done(sdone_a)
  );

  hdr_engine_sched #(.TIMEOUT_CYCLES(16), .CNT_W(5)) u_dut_b (
    .i_sys_clk(clk), .i_sys_rst(rst), .i_sched_en(sched_en_b),
    .i_regf_cmd_valid(cmd_valid), .i_regf_CP(cp), .i_regf_TOC(toc),
    .o_regf_cmd_pop(pop_b), .o_ccc_en(ccc_en_b), .i_ccc_done(ccc_done),
    .i_ccc_err_status(ccc_err), .i_ccc_ctrl(ccc_ctrl), .o_nt_en(nt_en_b),
    .i_nt_done(nt_done), .i_nt_err_status(nt_err), .i_nt_ctrl(nt_ctrl),
    .i_tx_mode_done(tx_done), .o_ctrl(ctrl_b), .o_resp_valid(resp_valid_b),
    .o_resp_err_status(err_b), .o_resp_is_ccc(is_ccc_b), .o_sched_done(sdone_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a descriptor for one cycle; returns in the first RUN cycle.
  task automatic issue(input logic c, input logic t);
    cmd_valid = 1'b1; cp = c; toc = t;
    tick();
    cmd_valid = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; sched_en_a = 1'b0; sched_en_b = 1'b0;
    cmd_valid = 1'b0; cp = 1'b0; toc = 1'b0;
    ccc_done = 1'b0; nt_done = 1'b0; tx_done = 1'b0;
    ccc_err = 4'h0; nt_err = 4'h0;
    ccc_ctrl = 17'h0ABCD; nt_ctrl = 17'h1F0F0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_ctrl", 32'(ctrl_a), 32'h0);
    check("rst_pop", 32'(pop_a), 32'h0);
    check("rst_en", 32'({ccc_en_a, nt_en_a}), 32'h0);
    check("rst_resp", 32'({resp_valid_a, err_a, is_ccc_a, sdone_a}), 32'h0);

    // CCC, TOC=0, done after 40 cycles -> Restart.
    sched_en_a = 1'b1;
    cmd_valid = 1'b1; cp = 1'b1; toc = 1'b0;
    tick();
    cmd_valid = 1'b0;
    check("t1_pop", 32'(pop_a), 32'h1);
    check("t1_en_early", 32'(ccc_en_a), 32'h0);
    tick();
    check("t1_pop_clr", 32'(pop_a), 32'h0);
    check("t1_ccc_en", 32'(ccc_en_a), 32'h1);
    check("t1_ctrl", 32'(ctrl_a), 32'h0ABCD);
    for (int i = 0; i < 38; i++) tick();
    check("t1_ccc_en_hold", 32'(ccc_en_a), 32'h1);
    ccc_done = 1'b1; ccc_err = 4'h0;
    tick();
    ccc_done = 1'b0;
    check("t1_resp", 32'({resp_valid_a, err_a, is_ccc_a}), 32'h21);
    check("t1_en_drop", 32'(ccc_en_a), 32'h0);
    tick();
    check("t1_restart", 32'(ctrl_a), 32'(CtrlRestart));
    check("t1_resp_pulse", 32'(resp_valid_a), 32'h0);
    tick();
    check("t1_restart_hold", 32'(ctrl_a), 32'(CtrlRestart));
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("t1_idle_ctrl", 32'(ctrl_a), 32'h0);
    check("t1_no_sdone", 32'(sdone_a), 32'h0);

    // NT, TOC=1 -> Exit + sched_done; stray CCC done is ignored.
    issue(1'b0, 1'b1);
    check("t2_nt_en", 32'({ccc_en_a, nt_en_a}), 32'h1);
    check("t2_ctrl", 32'(ctrl_a), 32'h1F0F0);
    ccc_done = 1'b1; ccc_err = 4'h5;
    tick();
    ccc_done = 1'b0;
    check("t2_ignore_ccc", 32'({nt_en_a, resp_valid_a}), 32'h2);
    nt_done = 1'b1; nt_err = 4'h0;
    tick();
    nt_done = 1'b0;
    check("t2_resp", 32'({resp_valid_a, err_a, is_ccc_a}), 32'h20);
    tick();
    check("t2_exit", 32'(ctrl_a), 32'(CtrlExit));
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("t2_sdone", 32'(sdone_a), 32'h1);
    tick();
    check("t2_sdone_pulse", 32'(sdone_a), 32'h0);

    // CCC error 2 with TOC=0 forces Exit.
    issue(1'b1, 1'b0);
    ccc_done = 1'b1; ccc_err = 4'h2;
    tick();
    ccc_done = 1'b0;
    check("t3_resp", 32'({resp_valid_a, err_a, is_ccc_a}), 32'h25);
    tick();
    check("t3_exit", 32'(ctrl_a), 32'(CtrlExit));
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("t3_sdone", 32'(sdone_a), 32'h1);
    tick();
    check("t3_err_hold", 32'(err_a), 32'h2);

    // Watchdog on DUT b: 16 RUN cycles then err F; done on the last cycle wins.
    sched_en_a = 1'b0; sched_en_b = 1'b1;
    issue(1'b1, 1'b0);
    for (int i = 0; i < 15; i++) tick();
    check("t4_last_run", 32'({ccc_en_b, resp_valid_b}), 32'h2);
    tick();
    check("t4_timeout", 32'({resp_valid_b, err_b, is_ccc_b}), 32'h3F);
    tick();
    check("t4_exit", 32'(ctrl_b), 32'(CtrlExit));
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("t4_sdone", 32'(sdone_b), 32'h1);
    check("t4_a_idle", 32'(pop_a | resp_valid_a | sdone_a), 32'h0);
    issue(1'b1, 1'b0);
    for (int i = 0; i < 15; i++) tick();
    ccc_done = 1'b1; ccc_err = 4'h3;
    tick();
    ccc_done = 1'b0;
    check("t4_done_wins", 32'({resp_valid_b, err_b}), 32'h13);
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    sched_en_b = 1'b0;

    // Abort mid-CCC_RUN, then a normal NT command after re-enable.
    sched_en_a = 1'b1;
    issue(1'b1, 1'b0);
    tick(); tick();
    sched_en_a = 1'b0;
    tick();
    check("t5_abort", 32'({ccc_en_a, resp_valid_a, ctrl_a}), 32'h0);
    tick();
    check("t5_no_resp", 32'({resp_valid_a, sdone_a}), 32'h0);
    sched_en_a = 1'b1;
    issue(1'b0, 1'b0);
    check("t5_nt_en", 32'(nt_en_a), 32'h1);
    nt_done = 1'b1; nt_err = 4'h0;
    tick();
    nt_done = 1'b0;
    check("t5_resp", 32'({resp_valid_a, err_a, is_ccc_a}), 32'h20);
    tick();
    check("t5_restart", 32'(ctrl_a), 32'(CtrlRestart));
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;

    // Back-to-back: NT bit 0 toggling never leaks; second pop 2 cycles after tx_done.
    issue(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      nt_ctrl[0] = ~nt_ctrl[0];
      #1;
      check("t6_no_leak", 32'(ctrl_a), 32'h0ABCD);
      tick();
    end
    ccc_done = 1'b1; ccc_err = 4'h0;
    tick();
    ccc_done = 1'b0;
    tick();
    check("t6_restart", 32'(ctrl_a), 32'(CtrlRestart));
    tx_done = 1'b1;
    cmd_valid = 1'b1; cp = 1'b0; toc = 1'b1;
    tick();
    tx_done = 1'b0;
    check("t6_no_pop_yet", 32'(pop_a), 32'h0);
    tick();
    check("t6_pop2", 32'(pop_a), 32'h1);
    cmd_valid = 1'b0;
    tick();
    check("t6_nt_en", 32'(nt_en_a), 32'h1);
    nt_done = 1'b1;
    tick();
    nt_done = 1'b0;
    tick();
    check("t6_exit", 32'(ctrl_a), 32'(CtrlExit));
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("t6_sdone", 32'(sdone_a), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hdr_engine_sched.md
Name: hdr_engine_sched

Overview:
- Sequences HDR-DDR command execution. Pops one command descriptor from the regfile and enables either the CCC engine (CCC_Handler) or the normal-transfer engine.
- Grants the shared datapath resources to that engine: tx, rx, bits counter, frame counter, SCL staller and SDA pp/od select.
- After each command, drives the tx block itself to emit an HDR Restart or Exit pattern.
- Returns a per-command response to the regfile.

Parameters:
TIMEOUT_CYCLES, 4095, watchdog limit in sys clocks per command in RUN states
CNT_W, 12, watchdog counter width (must hold TIMEOUT_CYCLES)
EXIT_MODE, 4'd10, tx_mode code for the HDR Exit pattern
RESTART_MODE, 4'd11, tx_mode code for the HDR Restart pattern

Ports:
i_sys_clk  in  1  system clock (50 MHz)
i_sys_rst  in  1  synchronous reset, active-high
i_sched_en  in  1  HDR-DDR mode active; low aborts everything
i_regf_cmd_valid  in  1  descriptor available at regfile head
i_regf_CP  in  1  1 = CCC command, 0 = normal transfer
i_regf_TOC  in  1  terminate on completion (Exit vs Restart)
o_regf_cmd_pop  out  1  one-cycle pulse, consumes descriptor
o_ccc_en  out  1  CCC engine enable (level)
i_ccc_done  in  1  CCC engine done pulse
i_ccc_err_status  in  4  CCC error code, valid with done
i_ccc_ctrl  in  17  CCC engine resource-control bundle
o_nt_en  out  1  normal-transfer engine enable (level)
i_nt_done  in  1  NT engine done pulse
i_nt_err_status  in  4  NT error code, valid with done
i_nt_ctrl  in  17  NT engine resource-control bundle
i_tx_mode_done  in  1  tx block finished current mode
o_ctrl  out  17  muxed bundle to the shared resources
o_resp_valid  out  1  one-cycle response pulse
o_resp_err_status  out  4  latched error code
o_resp_is_ccc  out  1  response belongs to a CCC
o_sched_done  out  1  one-cycle pulse when Exit pattern completes

Behaviour:
- Bundle field map, identical for i_ccc_ctrl, i_nt_ctrl and o_ctrl:
  - [0] tx_en
  - [4:1] tx_mode
  - [5] rx_en
  - [8:6] rx_mode
  - [9] bitcnt_en
  - [10] frmcnt_en
  - [11] sclstall_en
  - [15:12] sclstall_code
  - [16] sdahand_pp_od
- Reset: every output 0; state IDLE; watchdog 0; latched CP/TOC/err 0.
- FSM states: IDLE, FETCH, CCC_RUN, NT_RUN, RESP, RESTART, EXIT.
- IDLE:
  - If i_sched_en & i_regf_cmd_valid, go to FETCH.
  - o_ctrl = 0.
- FETCH (1 cycle):
  - Pulse o_regf_cmd_pop.
  - Latch CP and TOC.
  - Go to CCC_RUN if CP = 1, else NT_RUN.
- Enable latency: o_ccc_en / o_nt_en is high 2 cycles after cmd_valid is sampled in IDLE. The enable is registered and held for the whole RUN state.
- CCC_RUN / NT_RUN:
  - o_ctrl = the selected engine's bundle, combinational mux on registered state. The unselected bundle is ignored.
  - Watchdog increments every cycle in RUN.
  - Engine done: latch its err_status and go to RESP. The enable drops the same edge.
  - Watchdog reaching TIMEOUT_CYCLES: latch err = 4'hF and go to RESP.
  - Done and timeout in the same cycle: done wins.
- RESP (1 cycle):
  - Pulse o_resp_valid.
  - o_resp_err_status and o_resp_is_ccc hold their values until the next RESP.
  - Next state is EXIT if the latched TOC = 1 or the latched err != 0; otherwise RESTART.
- RESTART / EXIT:
  - o_ctrl = tx_en=1, tx_mode = RESTART_MODE / EXIT_MODE, sdahand_pp_od=1; all other fields 0.
  - Wait for i_tx_mode_done.
  - RESTART then goes to IDLE.
  - EXIT pulses o_sched_done on the transition edge, then goes to IDLE.
- Watchdog clears on entering FETCH.
- i_sched_en low in any non-IDLE state:
  - Next cycle: IDLE, enables 0, o_ctrl 0.
  - No response and no sched_done.
  - An already-issued pop is not undone.
- i_regf_cmd_valid is ignored outside IDLE. A done pulse from the non-enabled engine is ignored.
- i_tx_mode_done outside RESTART/EXIT is ignored.
- At most one engine enable is high at any time; an assertion checks this.

Test Plan:
- CCC command, CP=1, TOC=0; i_ccc_done with err 0 after 40 cycles:
  - pop at T+1, o_ccc_en at T+2, o_ctrl follows i_ccc_ctrl.
  - resp_valid with err 0, is_ccc=1.
  - o_ctrl tx_mode=11, tx_en=1 until tx_mode_done, then IDLE, no sched_done.
- NT command, CP=0, TOC=1; i_nt_done with err 0: o_nt_en high, o_ctrl equals i_nt_ctrl; resp is_ccc=0; EXIT tx_mode=10; sched_done pulses once.
- CCC done with err_status=4'h2 and TOC=0: resp err=2; forced EXIT (tx_mode=10) and sched_done.
- TIMEOUT_CYCLES=16, engine never finishes: after 16 RUN cycles resp err=4'hF, then EXIT. Done and timeout in the same cycle gives the engine err, not F.
- Deassert i_sched_en mid-CCC_RUN: next cycle o_ccc_en=0, o_ctrl=0, no resp_valid. A new command after re-enable runs normally.
- Back-to-back: two descriptors, the first with TOC=0. The second pop occurs exactly 2 cycles after the first Restart's tx_mode_done. Bit 0 of i_nt_ctrl toggled during CCC_RUN never reaches o_ctrl.
